// File: rtl/boot_pkg.sv
// boot_pkg: shared sync byte and loader state encoding
package boot_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR} boot_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with input synchronizer and stop-bit framing check
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
    logic [1:0]    sync_q, state_q, state_d;
    logic          armed_q, armed_d, valid_q, valid_d, ferr_q, ferr_d, rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    assign rx_s = sync_q[1];
    // armed_q doubles as the previous idle-line sample, so a start needs a high-to-low edge
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                armed_d = rx_s;
                cnt_d   = '0;
                if (armed_q && !rx_s) state_d = R_START;
            end
            R_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL) begin
                cnt_d  = '0;
                data_d = {rx_s, data_q[7:1]};
                bit_d  = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = R_STOP;
            end
            default: if (cnt_q == FULL) begin
                state_d = R_IDLE;
                armed_d = rx_s;
                valid_d = rx_s;
                ferr_d  = !rx_s;
            end
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            state_q <= R_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign frame_err_o  = ferr_q;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a checksummed program image from UART into instruction memory,
// holding the core in reset until the image is complete and verified
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_wdata,
    output logic                  o_core_rst_n,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
    boot_state_t           state_q, state_d;
    logic [CW-1:0]         n_q, n_d, words_q, words_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            sum_q, sum_d, rx_data;
    logic                  we_q, we_d, done_q, done_d, err_q, err_d, core_q, rx_valid, rx_ferr, n_ok;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [8:0]            n_ext;
    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .rx_i        (i_rx),
        .byte_valid_o(rx_valid),
        .byte_data_o (rx_data),
        .frame_err_o (rx_ferr)
    );
    // a count byte of zero stands for 256 words, legal only when the memory is that deep
    assign n_ext = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
    assign n_ok  = {23'd0, n_ext} <= DEPTH;
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        words_d = words_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        if (rx_ferr && state_q inside {S_COUNT, S_DATA, S_CHECK}) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE, S_ERR: if (rx_data == SYNC_BYTE) begin
                    state_d = S_COUNT;
                    err_d   = 1'b0;
                end
                S_COUNT: begin
                    state_d = n_ok ? S_DATA : S_ERR;
                    err_d   = !n_ok;
                    n_d     = CW'(n_ext);
                    words_d = '0;
                    bidx_d  = '0;
                    sum_d   = '0;
                end
                S_DATA: begin
                    sum_d  = sum_q + rx_data;
                    asm_d  = {asm_q[15:0], rx_data};
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        wdata_d = {asm_q, rx_data};
                        words_d = words_q + 1'b1;
                        if (words_d == n_q) state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
                    done_d  = rx_data == sum_q;
                    err_d   = rx_data != sum_q;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            words_q <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            core_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            core_q  <= done_q;
        end
    end
    assign o_we         = we_q;
    assign o_addr       = addr_q;
    assign o_wdata      = wdata_q;
    assign o_done       = done_q;
    assign o_error      = err_q;
    assign o_core_rst_n = core_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames over a fast UART with hand-computed expectations
module tb_uart_boot_loader;
    localparam int CPB = 8;
    localparam int AW  = 6;
    logic          i_clk = 1'b0, i_rst = 1'b1, i_rx = 1'b1;
    logic          o_we, o_core_rst_n, o_done, o_error;
    logic [AW-1:0] o_addr;
    logic [31:0]   o_wdata;
    int            n_chk = 0, n_fail = 0, cyc = 0, done_cyc = 0;
    logic          we_prev = 1'b0, done_prev = 1'b0, core_prev = 1'b0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [7:0]    nom[10] = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h00};

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .o_we(o_we), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_core_rst_n(o_core_rst_n), .o_done(o_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // write log plus pulse-width and done-to-core-release timing
    always @(negedge i_clk) begin
        if (o_we) begin
            chk("we_single_cycle", {31'd0, we_prev}, 0);
            wa.push_back(o_addr);
            wd.push_back(o_wdata);
        end
        if (o_done && !done_prev) begin
            chk("core_rst_n_low_at_done", {31'd0, o_core_rst_n}, 0);
            done_cyc = cyc;
        end
        if (o_core_rst_n && !core_prev) chk("core_rst_n_delay", cyc - done_cyc, 1);
        we_prev   = o_we;
        done_prev = o_done;
        core_prev = o_core_rst_n;
        cyc++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        repeat (CPB) @(negedge i_clk);
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            repeat (CPB) @(negedge i_clk);
        end
        i_rx = stop;
        repeat (CPB) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (CPB) @(negedge i_clk);
    endtask

    task automatic send_body(input logic [7:0] cks);
        for (int k = 0; k < 9; k++) send_byte(nom[k], 1'b1);
        send_byte(cks, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"}, {31'd0, o_we}, 0);
        chk({tag, "_addr"}, {26'd0, o_addr}, 0);
        chk({tag, "_wdata"}, o_wdata, 0);
        chk({tag, "_core_rst_n"}, {31'd0, o_core_rst_n}, 0);
        chk({tag, "_done"}, {31'd0, o_done}, 0);
        chk({tag, "_error"}, {31'd0, o_error}, 0);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4 * CPB) @(negedge i_clk);
        wa.delete();
        wd.delete();
    endtask

    task automatic check_nominal(input string tag);
        chk({tag, "_nwrites"}, wa.size(), 2);
        if (wa.size() >= 2) begin
            chk({tag, "_addr0"}, {26'd0, wa[0]}, 0);
            chk({tag, "_data0"}, wd[0], 32'h20080005);
            chk({tag, "_addr1"}, {26'd0, wa[1]}, 1);
            chk({tag, "_data1"}, wd[1], 32'h2009000A);
        end
        chk({tag, "_done"}, {31'd0, o_done}, 1);
        chk({tag, "_core_rst_n"}, {31'd0, o_core_rst_n}, 1);
        chk({tag, "_error"}, {31'd0, o_error}, 0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        #1 check_reset("reset");
        i_rst = 1'b0;
        repeat (4 * CPB) @(negedge i_clk);

        // garbage in IDLE, then a good frame; 0x60 is the byte sum of the two words
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_body(8'h60);
        repeat (20) @(negedge i_clk);
        check_nominal("nominal");

        apply_reset();
        send_byte(8'hA5, 1'b1);
        send_body(8'h61);
        repeat (20) @(negedge i_clk);
        chk("badsum_nwrites", wa.size(), 2);
        chk("badsum_error", {31'd0, o_error}, 1);
        chk("badsum_core_rst_n", {31'd0, o_core_rst_n}, 0);
        chk("badsum_done", {31'd0, o_done}, 0);
        wa.delete();
        wd.delete();
        send_byte(8'hA5, 1'b1);
        chk("resync_error_clear", {31'd0, o_error}, 0);
        send_body(8'h60);
        repeat (20) @(negedge i_clk);
        check_nominal("reload");

        apply_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("count0_error", {31'd0, o_error}, 1);
        send_byte(8'hA5, 1'b1);
        chk("count_resync_clear", {31'd0, o_error}, 0);
        send_byte(8'h41, 1'b1);
        chk("count65_error", {31'd0, o_error}, 1);
        chk("badcount_nwrites", wa.size(), 0);

        apply_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (20) @(negedge i_clk);
        chk("framing_error", {31'd0, o_error}, 1);
        chk("framing_nwrites", wa.size(), 0);
        chk("framing_done", {31'd0, o_done}, 0);

        // 64 words holding their index; sum of 0..63 = 2016 = 0xE0 mod 256
        apply_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        for (int w = 0; w < 64; w++) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'(w), 1'b1);
        end
        send_byte(8'hE0, 1'b1);
        repeat (20) @(negedge i_clk);
        chk("full_nwrites", wa.size(), 64);
        if (wa.size() == 64) begin
            for (int w = 0; w < 64; w++) begin
                chk("full_addr", {26'd0, wa[w]}, w);
                chk("full_data", wd[w], w);
            end
            chk("full_last_addr", {26'd0, wa[63]}, 63);
        end
        chk("full_done", {31'd0, o_done}, 1);
        chk("full_error", {31'd0, o_error}, 0);

        // reset while the second word's second byte (0x09) is mid-reception
        apply_reset();
        send_byte(8'hA5, 1'b1);
        for (int k = 0; k < 6; k++) send_byte(nom[k], 1'b1);
        chk("midload_wdata_before", o_wdata, 32'h20080005);
        i_rx = 1'b0;
        repeat (CPB) @(negedge i_clk);
        for (int k = 0; k < 3; k++) begin
            i_rx = nom[6][k];
            repeat (CPB) @(negedge i_clk);
        end
        i_rst = 1'b1;
        #1 check_reset("midload_reset");
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4 * CPB) @(negedge i_clk);
        wa.delete();
        wd.delete();
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_body(8'h60);
        repeat (20) @(negedge i_clk);
        check_nominal("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
